connect_n_game_core: RTL and testbench

Parametrised game engine for Connect-N: it holds the board state, the cursor column and the current player, and drops pieces into columns. After each drop it runs a sequential win and draw check. It sits between the debounced button inputs and the VGA renderer, which reads board cells through a registered read port. It generalises the fixed 7x6 connect-four game to any board size and win length, and adds restart and draw detection.

---
 rtl/connect_n_pkg.sv | 33 +++
 rtl/connect_n_if.sv | 32 +++
 rtl/connect_n_edge_detect.sv | 29 ++
 rtl/connect_n_game_core.sv | 221 ++++++++++++++++++++++
 tb/tb_connect_n_game_core.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/connect_n_pkg.sv
// Shared types for the Connect-N engine: cell encoding, FSM states and the
// four line directions with their (dcol, drow) unit steps.
package connect_n_pkg;

    typedef enum logic [1:0] {
        CELL_EMPTY = 2'd0,
        CELL_P1    = 2'd1,
        CELL_P2    = 2'd2
    } cell_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PLACE,
        ST_CHECK,
        ST_OVER
    } state_t;

    typedef enum logic [1:0] {
        DIR_H,
        DIR_V,
        DIR_D,
        DIR_A
    } dir_t;

    // Indexed by dir_t: horizontal, vertical, diagonal, anti-diagonal.
    localparam logic signed [1:0] DIR_DCOL [4] = '{2'sd1, 2'sd0, 2'sd1, 2'sd1};
    localparam logic signed [1:0] DIR_DROW [4] = '{2'sd0, 2'sd1, 2'sd1, -2'sd1};

    function automatic logic [1:0] other_player(input logic [1:0] p);
        return (p == CELL_P1) ? CELL_P2 : CELL_P1;
    endfunction

endpackage

// File: rtl/connect_n_if.sv
// Button, renderer read port and status bundle of the Connect-N engine.
interface connect_n_if #(
    parameter int COLS = 7,
    parameter int ROWS = 6
);
    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);

    logic          move_left;
    logic          move_right;
    logic          drop_piece;
    logic          restart;
    logic [CW-1:0] rd_col;
    logic [RW-1:0] rd_row;
    logic [1:0]    rd_cell;
    logic [CW-1:0] cursor_col;
    logic [1:0]    cur_player;
    logic          busy;
    logic          game_over;
    logic [1:0]    winner;

    modport master (
        output move_left, move_right, drop_piece, restart, rd_col, rd_row,
        input  rd_cell, cursor_col, cur_player, busy, game_over, winner
    );

    modport slave (
        input  move_left, move_right, drop_piece, restart, rd_col, rd_row,
        output rd_cell, cursor_col, cur_player, busy, game_over, winner
    );

endinterface

// File: rtl/connect_n_edge_detect.sv
// Rising-edge detector; history resets to 1 so a level held through reset
// never produces a pulse.
module connect_n_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);
    logic samp_q, samp_d;
    logic hist_q, hist_d;

    always_comb begin
        samp_d = din;
        hist_d = samp_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            samp_q <= 1'b1;
            hist_q <= 1'b1;
        end else begin
            samp_q <= samp_d;
            hist_q <= hist_d;
        end
    end

    assign pulse = samp_q & ~hist_q;

endmodule

// File: rtl/connect_n_game_core.sv
// Connect-N board, cursor and turn engine with a one-cell-per-cycle win scan.
// Define CONNECT_CURSOR_WRAP_EN to make the cursor wrap instead of saturate.
module connect_n_game_core
    import connect_n_pkg::*;
#(
    parameter int COLS    = 7,
    parameter int ROWS    = 6,
    parameter int WIN_LEN = 4
) (
    input  logic        clk,
    input  logic        rst,
    connect_n_if.slave  bus
);
    localparam int CW   = $clog2(COLS);
    localparam int RW   = $clog2(ROWS);
    localparam int HW   = $clog2(ROWS + 1);
    localparam int RUNW = $clog2(WIN_LEN + 1);
    localparam int CSW  = CW + 1;
    localparam int RSW  = RW + 1;
    localparam logic [RUNW-1:0] WIN_RUN   = RUNW'(WIN_LEN);
    localparam logic [RUNW-1:0] LAST_STEP = RUNW'(WIN_LEN - 1);
`ifdef CONNECT_CURSOR_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic [3:0] btn, pulse;
    assign btn = {bus.restart, bus.drop_piece, bus.move_right, bus.move_left};

    for (genvar i = 0; i < 4; i++) begin : g_edge
        connect_n_edge_detect u_edge (.clk(clk), .rst(rst), .din(btn[i]), .pulse(pulse[i]));
    end

    logic left_p, right_p, drop_p, restart_p;
    assign {restart_p, drop_p, right_p, left_p} = pulse;

    state_t                        state_q, state_d;
    logic [COLS-1:0][ROWS-1:0][1:0] board_q, board_d;
    logic [COLS-1:0][HW-1:0]       height_q, height_d;
    logic [CW-1:0]                 cursor_q, cursor_d;
    logic [1:0]                    player_q, player_d;
    logic [1:0]                    winner_q, winner_d;
    logic [CW-1:0]                 pc_q, pc_d;
    logic [RW-1:0]                 pr_q, pr_d;
    logic signed [CSW-1:0]         cc_q, cc_d;
    logic signed [RSW-1:0]         cr_q, cr_d;
    dir_t                          dir_q, dir_d;
    logic                          neg_q, neg_d;
    logic [RUNW-1:0]               run_q, run_d;
    logic [RUNW-1:0]               steps_q, steps_d;
    logic [1:0]                    rd_cell_q, rd_cell_d;

    // Probe of the next cell along the current direction and sense.
    logic signed [CSW-1:0] sc, nc;
    logic signed [RSW-1:0] sr, nr;
    logic                  in_bnd, hit, all_full, col_full, end_sense;
    logic [1:0]            probe_cell;
    logic [RUNW-1:0]       run_inc, steps_inc;

    always_comb begin
        sc = {{(CSW-2){DIR_DCOL[dir_q][1]}}, DIR_DCOL[dir_q]};
        sr = {{(RSW-2){DIR_DROW[dir_q][1]}}, DIR_DROW[dir_q]};
        if (neg_q) begin
            sc = -sc;
            sr = -sr;
        end
        nc = cc_q + sc;
        nr = cr_q + sr;
        in_bnd = (int'(nc) >= 0) && (int'(nc) < COLS) && (int'(nr) >= 0) && (int'(nr) < ROWS);
        probe_cell = in_bnd ? board_q[nc[CW-1:0]][nr[RW-1:0]] : CELL_EMPTY;
        hit = in_bnd && (probe_cell == player_q);
        run_inc   = run_q + RUNW'(1);
        steps_inc = steps_q + RUNW'(1);
        all_full = 1'b1;
        for (int c = 0; c < COLS; c++) begin
            if (height_q[c] != HW'(ROWS)) all_full = 1'b0;
        end
        col_full = (height_q[cursor_q] == HW'(ROWS));
    end

    always_comb begin
        state_d   = state_q;
        board_d   = board_q;
        height_d  = height_q;
        cursor_d  = cursor_q;
        player_d  = player_q;
        winner_d  = winner_q;
        pc_d      = pc_q;
        pr_d      = pr_q;
        cc_d      = cc_q;
        cr_d      = cr_q;
        dir_d     = dir_q;
        neg_d     = neg_q;
        run_d     = run_q;
        steps_d   = steps_q;
        end_sense = 1'b0;
        rd_cell_d = ((int'(bus.rd_col) < COLS) && (int'(bus.rd_row) < ROWS))
                    ? board_q[bus.rd_col][bus.rd_row] : CELL_EMPTY;

        case (state_q)
            ST_IDLE: begin
                if (restart_p) begin
                    state_d = ST_OVER;  // routed through the shared clear below
                end else if (drop_p) begin
                    if (!col_full) state_d = ST_PLACE;
                end else if (left_p && !right_p) begin
                    if (cursor_q == '0) cursor_d = WRAP ? CW'(COLS - 1) : cursor_q;
                    else                cursor_d = cursor_q - CW'(1);
                end else if (right_p && !left_p) begin
                    if (cursor_q == CW'(COLS - 1)) cursor_d = WRAP ? '0 : cursor_q;
                    else                           cursor_d = cursor_q + CW'(1);
                end
            end
            ST_PLACE: begin
                board_d[cursor_q][height_q[cursor_q][RW-1:0]] = player_q;
                height_d[cursor_q] = height_q[cursor_q] + HW'(1);
                pc_d    = cursor_q;
                pr_d    = height_q[cursor_q][RW-1:0];
                cc_d    = {1'b0, cursor_q};
                cr_d    = {1'b0, height_q[cursor_q][RW-1:0]};
                dir_d   = DIR_H;
                neg_d   = 1'b0;
                run_d   = RUNW'(1);
                steps_d = '0;
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (hit) begin
                    run_d = run_inc;
                    if (run_inc >= WIN_RUN) begin
                        winner_d = player_q;
                        state_d  = ST_OVER;
                    end else begin
                        cc_d      = nc;
                        cr_d      = nr;
                        steps_d   = steps_inc;
                        end_sense = (steps_inc == LAST_STEP);
                    end
                end else begin
                    end_sense = 1'b1;
                end
                // A failed probe retires the sense in the same cycle it was tried.
                if (end_sense) begin
                    cc_d    = {1'b0, pc_q};
                    cr_d    = {1'b0, pr_q};
                    steps_d = '0;
                    if (!neg_q) begin
                        neg_d = 1'b1;
                    end else begin
                        neg_d = 1'b0;
                        run_d = RUNW'(1);
                        if (dir_q != DIR_A) begin
                            dir_d = dir_t'(dir_q + 2'd1);
                        end else if (all_full) begin
                            winner_d = CELL_EMPTY;
                            state_d  = ST_OVER;
                        end else begin
                            player_d = other_player(player_q);
                            state_d  = ST_IDLE;
                        end
                    end
                end
            end
            default: ;
        endcase

        if ((state_q == ST_IDLE || state_q == ST_OVER) && restart_p) begin
            board_d  = '0;
            height_d = '0;
            cursor_d = CW'(COLS / 2);
            player_d = CELL_P1;
            winner_d = CELL_EMPTY;
            state_d  = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            board_q   <= '0;
            height_q  <= '0;
            cursor_q  <= CW'(COLS / 2);
            player_q  <= CELL_P1;
            winner_q  <= CELL_EMPTY;
            pc_q      <= '0;
            pr_q      <= '0;
            cc_q      <= '0;
            cr_q      <= '0;
            dir_q     <= DIR_H;
            neg_q     <= 1'b0;
            run_q     <= '0;
            steps_q   <= '0;
            rd_cell_q <= CELL_EMPTY;
        end else begin
            state_q   <= state_d;
            board_q   <= board_d;
            height_q  <= height_d;
            cursor_q  <= cursor_d;
            player_q  <= player_d;
            winner_q  <= winner_d;
            pc_q      <= pc_d;
            pr_q      <= pr_d;
            cc_q      <= cc_d;
            cr_q      <= cr_d;
            dir_q     <= dir_d;
            neg_q     <= neg_d;
            run_q     <= run_d;
            steps_q   <= steps_d;
            rd_cell_q <= rd_cell_d;
        end
    end

    assign bus.rd_cell    = rd_cell_q;
    assign bus.cursor_col = cursor_q;
    assign bus.cur_player = player_q;
    assign bus.busy       = (state_q == ST_PLACE) || (state_q == ST_CHECK);
    assign bus.game_over  = (state_q == ST_OVER);
    assign bus.winner     = winner_q;

endmodule

// File: tb/tb_connect_n_game_core.sv
// Scoreboarded bench: 7x6/4 engine for moves, wins, full column and busy
// behaviour; 4x4/3 engine for a full-board draw and restart.
module tb_connect_n_game_core;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    connect_n_if #(.COLS(7), .ROWS(6)) bus7();
    connect_n_if #(.COLS(4), .ROWS(4)) bus4();

    connect_n_game_core #(.COLS(7), .ROWS(6), .WIN_LEN(4)) dut  (.clk(clk), .rst(rst), .bus(bus7));
    connect_n_game_core #(.COLS(4), .ROWS(4), .WIN_LEN(3)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    localparam int O_CUR = 0, O_PLY = 1, O_BUSY = 2, O_OVER = 3, O_WIN = 4, O_CELL = 5;
    localparam int M_L = 1, M_R = 2, M_D = 4, M_RS = 8;

    typedef struct { string tag; int val; } exp_t;
    exp_t sb[$];
    int n_chk = 0, n_err = 0;
    int cur7 = 3, cur4 = 2;

    task automatic chk(input string tag, input int obs_v, input int exp_v);
        n_chk++;
        if (obs_v != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs_v, exp_v);
        end
    endtask

    task automatic push(input string tag, input int v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic pop(input int o);
        exp_t e;
        if (sb.size() == 0) begin
            e.tag = "sb_underflow";
            e.val = -1;
        end else begin
            e = sb.pop_front();
        end
        chk(e.tag, o, e.val);
    endtask

    function automatic int obs(input bit s, input int what);
        case (what)
            O_CUR:   return s ? int'(bus4.cursor_col) : int'(bus7.cursor_col);
            O_PLY:   return s ? int'(bus4.cur_player) : int'(bus7.cur_player);
            O_BUSY:  return s ? int'(bus4.busy)       : int'(bus7.busy);
            O_OVER:  return s ? int'(bus4.game_over)  : int'(bus7.game_over);
            O_WIN:   return s ? int'(bus4.winner)     : int'(bus7.winner);
            default: return s ? int'(bus4.rd_cell)    : int'(bus7.rd_cell);
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit s, input int m);
        if (s) begin
            bus4.move_left = m[0]; bus4.move_right = m[1]; bus4.drop_piece = m[2]; bus4.restart = m[3];
        end else begin
            bus7.move_left = m[0]; bus7.move_right = m[1]; bus7.drop_piece = m[2]; bus7.restart = m[3];
        end
    endtask

    task automatic press(input bit s, input int m);
        drive(s, m);
        tick(1);
        drive(s, 0);
        tick(1);
    endtask

    task automatic wait_idle(input bit s);
        for (int i = 0; i < 100; i++) begin
            if (obs(s, O_BUSY) == 0) break;
            tick(1);
        end
        if (obs(s, O_BUSY) != 0) chk("busy_timeout", obs(s, O_BUSY), 0);
    endtask

    task automatic move_to(input bit s, input int col);
        int c;
        c = s ? cur4 : cur7;
        while (c < col) begin press(s, M_R); c++; end
        while (c > col) begin press(s, M_L); c--; end
        if (s) cur4 = c; else cur7 = c;
    endtask

    task automatic drop_at(input bit s, input string tag, input int col,
                           input int ply, input int over, input int win);
        move_to(s, col);
        push({tag, "_player"}, ply);
        push({tag, "_over"}, over);
        push({tag, "_winner"}, win);
        press(s, M_D);
        wait_idle(s);
        pop(obs(s, O_PLY));
        pop(obs(s, O_OVER));
        pop(obs(s, O_WIN));
    endtask

    task automatic read_cell(input bit s, input string tag, input int c, input int r, input int v);
        push(tag, v);
        if (s) begin bus4.rd_col = 2'(c); bus4.rd_row = 2'(r); end
        else   begin bus7.rd_col = 3'(c); bus7.rd_row = 3'(r); end
        tick(1);
        pop(obs(s, O_CELL));
    endtask

    task automatic restart_game(input bit s, input string tag);
        push({tag, "_over"}, 0);
        push({tag, "_winner"}, 0);
        push({tag, "_player"}, 1);
        push({tag, "_cursor"}, s ? 2 : 3);
        press(s, M_RS);
        tick(1);
        pop(obs(s, O_OVER));
        pop(obs(s, O_WIN));
        pop(obs(s, O_PLY));
        pop(obs(s, O_CUR));
        if (s) cur4 = 2; else cur7 = 3;
    endtask

    initial begin
        int ord [8] = '{0, 2, 1, 3, 2, 0, 3, 1};
        int exp_c, mx;
        drive(0, M_R);  // held high through reset: must not count as an edge
        drive(1, 0);
        bus7.rd_col = '0; bus7.rd_row = '0;
        bus4.rd_col = '0; bus4.rd_row = '0;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(2);
        drive(0, 0);
        tick(2);

        push("rst_cursor", 3); push("rst_player", 1); push("rst_busy", 0);
        push("rst_over", 0);   push("rst_winner", 0); push("rst_cursor4", 2);
        pop(obs(0, O_CUR)); pop(obs(0, O_PLY)); pop(obs(0, O_BUSY));
        pop(obs(0, O_OVER)); pop(obs(0, O_WIN)); pop(obs(1, O_CUR));
        read_cell(0, "rst_cell", 0, 0, 0);

        // Cursor stepping right to the edge, then one more.
        for (int i = 0; i < 4; i++) begin
`ifdef CONNECT_CURSOR_WRAP_EN
            exp_c = (i < 3) ? 4 + i : 0;
`else
            exp_c = (i < 3) ? 4 + i : 6;
`endif
            push($sformatf("cursor_r%0d", i), exp_c);
            press(0, M_R);
            pop(obs(0, O_CUR));
            cur7 = exp_c;
        end
        push("cursor_lr_same", cur7);
        press(0, M_L | M_R);
        pop(obs(0, O_CUR));

        // Horizontal win for player 1 on row 0.
        drop_at(0, "h1", 0, 2, 0, 0);
        drop_at(0, "h2", 6, 1, 0, 0);
        drop_at(0, "h3", 1, 2, 0, 0);
        drop_at(0, "h4", 6, 1, 0, 0);
        drop_at(0, "h5", 2, 2, 0, 0);
        drop_at(0, "h6", 6, 1, 0, 0);
        drop_at(0, "h7", 3, 1, 1, 1);
        read_cell(0, "h_cell30", 3, 0, 1);
        read_cell(0, "h_cell62", 6, 2, 2);
        read_cell(0, "h_cell63", 6, 3, 0);
        read_cell(0, "h_oob_col", 7, 0, 0);
        read_cell(0, "h_oob_row", 6, 6, 0);
        push("over_move", 3);
        press(0, M_R);
        pop(obs(0, O_CUR));
        push("over_drop_busy", 0);
        push("over_drop_player", 1);
        press(0, M_D);
        pop(obs(0, O_BUSY));
        pop(obs(0, O_PLY));
        read_cell(0, "over_cell31", 3, 1, 0);
        restart_game(0, "rs1");
        read_cell(0, "rs1_cell30", 3, 0, 0);
        read_cell(0, "rs1_cell60", 6, 0, 0);

        // Vertical win for player 2 in column 5.
        drop_at(0, "v1", 0, 2, 0, 0);
        drop_at(0, "v2", 5, 1, 0, 0);
        drop_at(0, "v3", 1, 2, 0, 0);
        drop_at(0, "v4", 5, 1, 0, 0);
        drop_at(0, "v5", 0, 2, 0, 0);
        drop_at(0, "v6", 5, 1, 0, 0);
        drop_at(0, "v7", 1, 2, 0, 0);
        drop_at(0, "v8", 5, 2, 1, 2);
        read_cell(0, "v_cell53", 5, 3, 2);
        read_cell(0, "v_cell11", 1, 1, 1);
        push("v_ign_over", 1);
        press(0, M_D);
        wait_idle(0);
        pop(obs(0, O_OVER));
        read_cell(0, "v_cell54", 5, 4, 0);
        restart_game(0, "rs2");

        // Fill column 0, then drop into it once more.
        for (int i = 0; i < 6; i++)
            drop_at(0, $sformatf("f%0d", i), 0, (i % 2 == 0) ? 2 : 1, 0, 0);
        push("full_busy", 0);
        push("full_player", 1);
        mx = 0;
        drive(0, M_D);
        for (int i = 0; i < 6; i++) begin
            tick(1);
            drive(0, 0);
            mx = mx | obs(0, O_BUSY);
        end
        pop(mx);
        pop(obs(0, O_PLY));
        read_cell(0, "full_cell05", 0, 5, 2);
        drop_at(0, "full_next", 1, 2, 0, 0);
        read_cell(0, "full_next10", 1, 0, 1);

        // Drop with a move in the same cycle, then drop+restart while busy.
        push("dm_cursor", 1);
        press(0, M_D | M_R);
        pop(obs(0, O_CUR));
        push("dm_busy", 1);
        pop(obs(0, O_BUSY));
        press(0, M_D | M_RS);
        wait_idle(0);
        push("dm_player", 1);
        push("dm_over", 0);
        pop(obs(0, O_PLY));
        pop(obs(0, O_OVER));
        read_cell(0, "dm_cell11", 1, 1, 2);
        read_cell(0, "dm_cell12", 1, 2, 0);
        read_cell(0, "dm_cell00", 0, 0, 1);

        // Reset in the middle of a check.
        press(0, M_D);
        tick(2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);
        cur7 = 3;
        cur4 = 2;
        push("mid_rst_busy", 0);
        push("mid_rst_cursor", 3);
        pop(obs(0, O_BUSY));
        pop(obs(0, O_CUR));
        read_cell(0, "mid_rst_cell12", 1, 2, 0);
        read_cell(0, "mid_rst_cell00", 0, 0, 0);

        // 4x4, WIN_LEN=3: 2x2-block checker pattern fills the board with no line.
        for (int k = 0; k < 16; k++)
            drop_at(1, $sformatf("d%0d", k), ord[((k / 4) % 2) * 4 + (k % 4)],
                    (k == 15) ? 2 : ((k % 2 == 0) ? 2 : 1),
                    (k == 15) ? 1 : 0, 0);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                read_cell(1, $sformatf("draw_c%0d%0d", c, r), c, r, (((c / 2) + r) % 2 == 0) ? 1 : 2);
        restart_game(1, "rs4");
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                read_cell(1, $sformatf("clr_c%0d%0d", c, r), c, r, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
